// File: rtl/tile_text_display.sv
// Text-mode tile renderer: COLSxROWS cell RAM drawn through the digit glyph ROM,
// with a blanking-only host write port, a hardware fill engine and row scrolling.
module tile_text_display #(
  parameter  int unsigned COLS_LOG2 = 5,
  parameter  int unsigned ROWS_LOG2 = 5,
  parameter  int unsigned CELL_LOG2 = 3,
  localparam int unsigned ADDR_W    = COLS_LOG2 + ROWS_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 display_on,
  output logic [2:0]           rgb,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 wr_ack,
  input  logic                 fill_start,
  input  logic [7:0]           fill_data,
  output logic                 busy,
  input  logic [ROWS_LOG2-1:0] scroll_y
);

  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam int unsigned GRID_W_LOG2 = COLS_LOG2 + CELL_LOG2;
  localparam int unsigned GRID_H_LOG2 = ROWS_LOG2 + CELL_LOG2;

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  // 5x5 digit glyphs, rows 5..7 and digits 10..15 blank
  function automatic logic [4:0] glyph_bits(input logic [3:0] digit, input logic [2:0] yofs);
    logic [4:0] bits;
    bits = 5'b00000;
    case ({digit, yofs})
      7'o000: bits = 5'b11111; 7'o001: bits = 5'b10001; 7'o002: bits = 5'b10001;
      7'o003: bits = 5'b10001; 7'o004: bits = 5'b11111;
      7'o010: bits = 5'b01100; 7'o011: bits = 5'b00100; 7'o012: bits = 5'b00100;
      7'o013: bits = 5'b00100; 7'o014: bits = 5'b11111;
      7'o020: bits = 5'b11111; 7'o021: bits = 5'b00001; 7'o022: bits = 5'b11111;
      7'o023: bits = 5'b10000; 7'o024: bits = 5'b11111;
      7'o030: bits = 5'b11111; 7'o031: bits = 5'b00001; 7'o032: bits = 5'b11111;
      7'o033: bits = 5'b00001; 7'o034: bits = 5'b11111;
      7'o040: bits = 5'b10001; 7'o041: bits = 5'b10001; 7'o042: bits = 5'b11111;
      7'o043: bits = 5'b00001; 7'o044: bits = 5'b00001;
      7'o050: bits = 5'b11111; 7'o051: bits = 5'b10000; 7'o052: bits = 5'b11111;
      7'o053: bits = 5'b00001; 7'o054: bits = 5'b11111;
      7'o060: bits = 5'b11111; 7'o061: bits = 5'b10000; 7'o062: bits = 5'b11111;
      7'o063: bits = 5'b10001; 7'o064: bits = 5'b11111;
      7'o070: bits = 5'b11111; 7'o071: bits = 5'b00001; 7'o072: bits = 5'b00001;
      7'o073: bits = 5'b00001; 7'o074: bits = 5'b00001;
      7'o100: bits = 5'b11111; 7'o101: bits = 5'b10001; 7'o102: bits = 5'b11111;
      7'o103: bits = 5'b10001; 7'o104: bits = 5'b11111;
      7'o110: bits = 5'b11111; 7'o111: bits = 5'b10001; 7'o112: bits = 5'b11111;
      7'o113: bits = 5'b00001; 7'o114: bits = 5'b11111;
      default: bits = 5'b00000;
    endcase
    return bits;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          fill_byte_q, fill_byte_d;
  logic [ROWS_LOG2-1:0] scroll_q, scroll_eff;

  logic                frame_start;
  logic [ROWS_LOG2-1:0] vid_row;
  logic [COLS_LOG2-1:0] vid_col;
  logic                ingrid;

  logic [7:0]          mem [DEPTH];
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr, ram_addr;
  logic [7:0]          ram_wdata, ram_q;

  logic                de_d1, ingrid_d1;
  logic [CELL_LOG2-1:0] xofs_d1;
  logic [2:0]          yofs_d1;
  logic [4:0]          glyph;
  logic                glyph_on, pixel;
  logic [2:0]          rgb_d;

  // Stage 0: cell address; scroll taken live at frame start so the whole frame agrees
  assign frame_start = (hpos == 10'd0) && (vpos == 10'd0);
  assign scroll_eff  = frame_start ? scroll_y : scroll_q;
  assign vid_row     = ROWS_LOG2'(vpos >> CELL_LOG2) + scroll_eff;
  assign vid_col     = COLS_LOG2'(hpos >> CELL_LOG2);
  assign ingrid      = (32'(hpos) < (32'd1 << GRID_W_LOG2)) &&
                       (32'(vpos) < (32'd1 << GRID_H_LOG2));

  always_ff @(posedge clk) begin
    if (reset) scroll_q <= '0;
    else if (frame_start) scroll_q <= scroll_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fill_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_byte_q <= fill_byte_d;
    end
  end

  // Writers only touch the RAM during blanking; fill beats a simultaneous host request
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_byte_d = fill_byte_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_addr;
    ram_wdata   = wr_data;
    wr_ack      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d     = ST_FILL;
          cnt_d       = '0;
          fill_byte_d = fill_data;
        end else if (wr_req && !display_on) begin
          ram_we = 1'b1;
          wr_ack = 1'b1;
        end
      end
      ST_FILL: begin
        if (!display_on) begin
          ram_we    = 1'b1;
          ram_waddr = cnt_q;
          ram_wdata = fill_byte_q;
          cnt_d     = cnt_q + ADDR_W'(1);
          if (cnt_q == '1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      ram_we = 1'b0;
      wr_ack = 1'b0;
    end
  end

  assign busy     = (state_q == ST_FILL);
  assign ram_addr = display_on ? {vid_row, vid_col} : ram_waddr;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  // Stage 1: pixel coordinates travel alongside the RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      de_d1     <= 1'b0;
      ingrid_d1 <= 1'b0;
      xofs_d1   <= '0;
      yofs_d1   <= 3'd0;
    end else begin
      de_d1     <= display_on;
      ingrid_d1 <= ingrid;
      xofs_d1   <= hpos[CELL_LOG2-1:0];
      yofs_d1   <= vpos[CELL_LOG2-1 -: 3];
    end
  end

  // Stage 2: glyph lookup and colour
  always_comb begin
    glyph    = glyph_bits(ram_q[3:0], yofs_d1);
    glyph_on = (32'(xofs_d1) < 32'd5) && (|(glyph & (5'b10000 >> xofs_d1)));
    pixel    = glyph_on ^ ram_q[7];
    rgb_d    = (de_d1 && ingrid_d1 && pixel) ? ram_q[6:4] : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) rgb <= 3'b000;
    else rgb <= rgb_d;
  end

endmodule
